// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared constants and state encoding for the conv stream feeder
package conv_pkg;

    localparam int DATA_WIDTH    = 64;
    localparam int INPUT_DIM     = 4;
    localparam int KERNEL_SIZE   = 9;
    localparam int MAX_ROW_WIDTH = 9;
    localparam int MAX_COL_WIDTH = 9;
    localparam int ADDR_WIDTH    = 18;
    localparam int PIX_WIDTH     = MAX_ROW_WIDTH + MAX_COL_WIDTH;
    localparam int WORD_WIDTH    = DATA_WIDTH * INPUT_DIM;
    localparam int CLR_LEN       = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_WGT,
        ST_GAP,
        ST_DAT,
        ST_DRAIN,
        ST_DONE
    } feeder_state_e;

endpackage

// File: rtl/conv_rd_align.sv
// rtl/conv_rd_align.sv - aligns buffer read data to weight/pixel qualifiers
module conv_rd_align #(
    parameter int WordWidth = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rd_en,
    input  logic                 is_data,
    input  logic [WordWidth-1:0] rdata,
    output logic [WordWidth-1:0] weight_out,
    output logic                 weight_valid,
    output logic [WordWidth-1:0] data_out,
    output logic                 data_valid
);

    logic wv_q, wv_d;
    logic dv_q, dv_d;

    // Read data returns one cycle after the strobe; tag it with the phase of that strobe.
    always_comb begin
        wv_d = rd_en && !is_data;
        dv_d = rd_en && is_data;
    end

    // Delay the tagged strobe by the buffer read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            wv_q <= 1'b0;
            dv_q <= 1'b0;
        end else begin
            wv_q <= wv_d;
            dv_q <= dv_d;
        end
    end

    assign weight_valid = wv_q;
    assign data_valid   = dv_q;
    assign weight_out   = wv_q ? rdata : '0;
    assign data_out     = dv_q ? rdata : '0;

endmodule

// File: rtl/conv_stream_feeder.sv
// rtl/conv_stream_feeder.sv - weight/pixel sequencer for the conv core (optional FEEDER_PERF_EN cycle counter)
module conv_stream_feeder
    import conv_pkg::*;
#(
    parameter int DataWidth   = DATA_WIDTH,
    parameter int InputDim    = INPUT_DIM,
    parameter int KernelSize  = KERNEL_SIZE,
    parameter int MaxRowWidth = MAX_ROW_WIDTH,
    parameter int MaxColWidth = MAX_COL_WIDTH,
    parameter int AddrWidth   = ADDR_WIDTH
) (
    input  logic                          Clk,
    input  logic                          Rst,
    input  logic                          start,
    input  logic [MaxRowWidth-1:0]        row_in,
    input  logic [MaxColWidth-1:0]        col_in,
    input  logic [AddrWidth-1:0]          weight_base,
    input  logic [AddrWidth-1:0]          data_base,
    output logic                          mem_rd_en,
    output logic [AddrWidth-1:0]          mem_addr,
    input  logic [InputDim*DataWidth-1:0] mem_rdata,
    output logic                          conv_rst,
    output logic [MaxRowWidth-1:0]        row_out,
    output logic [MaxColWidth-1:0]        col_out,
    output logic [InputDim*DataWidth-1:0] weight_out,
    output logic                          weight_valid,
    output logic [InputDim*DataWidth-1:0] data_out,
    output logic                          data_valid,
    output logic                          busy,
    output logic                          done,
    output logic                          cfg_err
`ifdef FEEDER_PERF_EN
    ,
    output logic [31:0]                   perf_cycles
`endif
);

    localparam int PixWidth  = MaxRowWidth + MaxColWidth;
    localparam int WordWidth = InputDim * DataWidth;
    localparam logic [PixWidth-1:0] CNT_ONE  = PixWidth'(1);
    localparam logic [PixWidth-1:0] CLR_LAST = PixWidth'(CLR_LEN - 1);
    localparam logic [PixWidth-1:0] WGT_LAST = PixWidth'(KernelSize - 1);

    feeder_state_e          state_q, state_d;
    logic [PixWidth-1:0]    cnt_q, cnt_d;
    logic [PixWidth-1:0]    pix_q, pix_d;
    logic [MaxRowWidth-1:0] row_q, row_d;
    logic [MaxColWidth-1:0] col_q, col_d;
    logic [AddrWidth-1:0]   wbase_q, wbase_d;
    logic [AddrWidth-1:0]   dbase_q, dbase_d;
    logic [AddrWidth-1:0]   addr_q, addr_d;
    logic                   rd_en_q, rd_en_d;
    logic                   is_data_q, is_data_d;
    logic                   done_q, done_d;
    logic                   cfg_err_q, cfg_err_d;
    logic                   accept;

    // Next-state and registered-output logic; outputs are derived from the next state so they line up with it.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pix_d     = pix_q;
        row_d     = row_q;
        col_d     = col_q;
        wbase_d   = wbase_q;
        dbase_d   = dbase_q;
        cfg_err_d = 1'b0;
        accept    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (row_in != '0 && col_in != '0) begin
                        accept  = 1'b1;
                        state_d = ST_CLR;
                        cnt_d   = '0;
                        row_d   = row_in;
                        col_d   = col_in;
                        wbase_d = weight_base;
                        dbase_d = data_base;
                        pix_d   = PixWidth'(row_in) * PixWidth'(col_in);
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            ST_CLR: begin
                if (cnt_q == CLR_LAST) begin
                    state_d = ST_WGT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_WGT: begin
                if (cnt_q == WGT_LAST) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_GAP: begin
                state_d = ST_DAT;
                cnt_d   = '0;
            end
            ST_DAT: begin
                if (cnt_q == pix_q - CNT_ONE) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        rd_en_d   = (state_d == ST_WGT) || (state_d == ST_DAT);
        is_data_d = (state_d == ST_DAT);
        done_d    = (state_d == ST_DONE);
        if (!rd_en_d) begin
            addr_d = '0;
        end else if (is_data_d) begin
            addr_d = dbase_d + AddrWidth'(cnt_d);
        end else begin
            addr_d = wbase_d + AddrWidth'(cnt_d);
        end
    end

    // Sequencer state and registered outputs; reset aborts a run without a done pulse.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            pix_q     <= '0;
            row_q     <= '0;
            col_q     <= '0;
            wbase_q   <= '0;
            dbase_q   <= '0;
            addr_q    <= '0;
            rd_en_q   <= 1'b0;
            is_data_q <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pix_q     <= pix_d;
            row_q     <= row_d;
            col_q     <= col_d;
            wbase_q   <= wbase_d;
            dbase_q   <= dbase_d;
            addr_q    <= addr_d;
            rd_en_q   <= rd_en_d;
            is_data_q <= is_data_d;
            done_q    <= done_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign mem_rd_en = rd_en_q;
    assign mem_addr  = addr_q;
    assign row_out   = row_q;
    assign col_out   = col_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign cfg_err   = cfg_err_q;
    assign conv_rst  = Rst || (state_q == ST_CLR);

    conv_rd_align #(
        .WordWidth (WordWidth)
    ) u_rd_align (
        .clk          (Clk),
        .rst          (Rst),
        .rd_en        (rd_en_q),
        .is_data      (is_data_q),
        .rdata        (mem_rdata),
        .weight_out   (weight_out),
        .weight_valid (weight_valid),
        .data_out     (data_out),
        .data_valid   (data_valid)
    );

`ifdef FEEDER_PERF_EN
    logic [31:0] perf_q, perf_d;

    // Busy-cycle counter: cleared by an accepted start, holds once the run returns to idle.
    always_comb begin
        perf_d = perf_q;
        if (accept) begin
            perf_d = '0;
        end else if (busy) begin
            perf_d = perf_q + 32'd1;
        end
    end

    // Counter register.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_conv_stream_feeder.sv
// tb/tb_conv_stream_feeder.sv - scoreboard bench for conv_stream_feeder
module tb_conv_stream_feeder;

    logic         Clk = 1'b0;
    logic         Rst = 1'b1;
    logic         start = 1'b0;
    logic [8:0]   row_in = '0;
    logic [8:0]   col_in = '0;
    logic [17:0]  weight_base = '0;
    logic [17:0]  data_base = '0;
    logic         mem_rd_en;
    logic [17:0]  mem_addr;
    logic [255:0] mem_rdata = '0;
    logic         conv_rst;
    logic [8:0]   row_out;
    logic [8:0]   col_out;
    logic [255:0] weight_out;
    logic         weight_valid;
    logic [255:0] data_out;
    logic         data_valid;
    logic         busy;
    logic         done;
    logic         cfg_err;

    conv_stream_feeder dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .start        (start),
        .row_in       (row_in),
        .col_in       (col_in),
        .weight_base  (weight_base),
        .data_base    (data_base),
        .mem_rd_en    (mem_rd_en),
        .mem_addr     (mem_addr),
        .mem_rdata    (mem_rdata),
        .conv_rst     (conv_rst),
        .row_out      (row_out),
        .col_out      (col_out),
        .weight_out   (weight_out),
        .weight_valid (weight_valid),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .busy         (busy),
        .done         (done),
        .cfg_err      (cfg_err)
    );

    always #5 Clk = ~Clk;

    function automatic logic [255:0] word(input logic [17:0] a);
        return {{2'd3, 44'd0, a}, {2'd2, 44'd0, a}, {2'd1, 44'd0, a}, {2'd0, 44'd0, a}};
    endfunction

    always @(posedge Clk) begin
        if (mem_rd_en) mem_rdata <= word(mem_addr);
    end

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int t0 = 0;
    logic [255:0] wq[$];
    logic [255:0] dq[$];
    int rst_first, rst_last, rst_cnt;
    int wv_first, wv_last, wv_cnt;
    int dv_first, dv_last, dv_cnt;
    int done_at, done_cnt, busy_cnt, rd_cnt, err_cnt;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check_w(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic check_i(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic clear_stats();
        rst_first = -1; rst_last = -1; rst_cnt = 0;
        wv_first = -1; wv_last = -1; wv_cnt = 0;
        dv_first = -1; dv_last = -1; dv_cnt = 0;
        done_at = -1; done_cnt = 0; busy_cnt = 0; rd_cnt = 0; err_cnt = 0;
    endtask

    // Monitor: pops the scoreboard on every qualified word and tallies event timing.
    always @(negedge Clk) begin
        int rel;
        logic [255:0] exp;
        rel = cyc - t0;
        if (conv_rst && !Rst) begin
            if (rst_first < 0) rst_first = rel;
            rst_last = rel; rst_cnt++;
        end
        if (weight_valid) begin
            if (wv_first < 0) wv_first = rel;
            wv_last = rel; wv_cnt++;
            if (wq.size() == 0) begin
                check_i("weight_unexpected", 1, 0);
            end else begin
                exp = wq.pop_front();
                check_w("weight_out", weight_out, exp);
            end
        end
        if (data_valid) begin
            if (dv_first < 0) dv_first = rel;
            dv_last = rel; dv_cnt++;
            if (dq.size() == 0) begin
                check_i("data_unexpected", 1, 0);
            end else begin
                exp = dq.pop_front();
                check_w("data_out", data_out, exp);
            end
        end
        if (done) begin
            done_at = rel; done_cnt++;
        end
        if (busy) busy_cnt++;
        if (mem_rd_en) rd_cnt++;
        if (cfg_err) err_cnt++;
    end

    // One run: pushes expectations, pulses start, optionally a second start and a reset at given cycles.
    task automatic run_case(input int row, input int col, input logic [17:0] wb, input logic [17:0] db,
                            input int extra_at, input int rst_at);
        logic [17:0] a;
        int n;
        n = row * col;
        for (int k = 0; k < 9; k++) begin
            a = wb + 18'(k);
            wq.push_back(word(a));
        end
        for (int p = 0; p < n; p++) begin
            a = db + 18'(p);
            dq.push_back(word(a));
        end
        clear_stats();
        @(posedge Clk); #1;
        t0 = cyc;
        start = 1'b1; row_in = 9'(row); col_in = 9'(col); weight_base = wb; data_base = db;
        for (int i = 1; i < 20 + n; i++) begin
            @(posedge Clk); #1;
            start = 1'b0; row_in = 9'(row); col_in = 9'(col);
            Rst = 1'b0;
            if (i == extra_at) begin
                start = 1'b1; row_in = 9'd2; col_in = 9'd3;
            end
            if (i == rst_at) begin
                Rst = 1'b1;
                #1 check_i("conv_rst_during_rst", int'(conv_rst), 1);
            end
            if (rst_at > 0 && i == rst_at + 1) begin
                check_i("abort_busy", int'(busy), 0);
                check_i("abort_wv", int'(weight_valid), 0);
                check_i("abort_dv", int'(data_valid), 0);
                check_i("abort_rd", int'(mem_rd_en), 0);
            end
        end
    endtask

    task automatic check_run(input int n, input int row, input int col);
        check_i("conv_rst_first", rst_first, 1);
        check_i("conv_rst_cnt", rst_cnt, 2);
        check_i("wv_first", wv_first, 4);
        check_i("wv_last", wv_last, 12);
        check_i("wv_cnt", wv_cnt, 9);
        check_i("dv_first", dv_first, 14);
        check_i("dv_run_len", dv_last - dv_first + 1, n);
        check_i("dv_cnt", dv_cnt, n);
        check_i("done_at", done_at, 14 + n);
        check_i("done_cnt", done_cnt, 1);
        check_i("busy_cnt", busy_cnt, 14 + n);
        check_i("row_out", int'(row_out), row);
        check_i("col_out", int'(col_out), col);
        check_i("wq_left", wq.size(), 0);
        check_i("dq_left", dq.size(), 0);
    endtask

    initial begin
        clear_stats();
        repeat (3) @(posedge Clk);
        #1;
        check_i("rst_busy", int'(busy), 0);
        check_i("rst_conv_rst", int'(conv_rst), 1);
        check_i("rst_done", int'(done), 0);
        check_i("rst_rd_en", int'(mem_rd_en), 0);
        check_i("rst_row_out", int'(row_out), 0);
        check_i("rst_valids", int'(weight_valid) + int'(data_valid), 0);
        Rst = 1'b0;
        @(posedge Clk); #1;

        run_case(4, 4, 18'h00100, 18'h00200, -1, -1);
        check_run(16, 4, 4);

        run_case(4, 4, 18'h00100, 18'h00200, 10, -1);
        check_run(16, 4, 4);

        clear_stats();
        @(posedge Clk); #1;
        t0 = cyc;
        start = 1'b1; row_in = 9'd0; col_in = 9'd5;
        @(posedge Clk); #1;
        start = 1'b0;
        repeat (6) @(posedge Clk);
        #1;
        check_i("cfg_err_cnt", err_cnt, 1);
        check_i("cfg_err_busy", busy_cnt, 0);
        check_i("cfg_err_rd", rd_cnt, 0);
        check_i("cfg_err_row_keep", int'(row_out), 4);
        check_i("cfg_err_col_keep", int'(col_out), 4);

        run_case(4, 4, 18'h00100, 18'h00200, -1, 15);
        check_i("abort_no_done", done_cnt, 0);
        wq.delete();
        dq.delete();

        run_case(4, 4, 18'h00040, 18'h00300, -1, -1);
        check_run(16, 4, 4);

        run_case(2, 2, 18'h3FFF8, 18'h3FFFE, -1, -1);
        check_run(4, 2, 2);

        run_case(3, 5, 18'h01000, 18'h02000, -1, -1);
        check_run(15, 3, 5);

        run_case(1, 1, 18'h00010, 18'h00020, -1, -1);
        check_run(1, 1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
